prism_axi_id_retirer: RTL

Releasing end of the AXI ID pool: records the order in which IDs are issued on AR/AW and snoops R/B responses to see which transactions finish. It returns IDs to the ID allocator's dealloc port strictly in issue order once their final beat has arrived. Sits beside the AXI master port, between the DMA engine's address issue path and `prism_axi_id_allocator`.

---
 rtl/prism_axi_id_pkg.sv | 22 ++
 rtl/prism_axi_id_order_fifo.sv | 90 +++++++++
 rtl/prism_axi_id_retirer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prism_axi_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prism_axi_id_pkg
//  Description : Shared types and defaults for the AXI ID retirement path.
//                Provides the retire FSM state encoding and the default ID
//                pool size, which must match prism_axi_id_allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package prism_axi_id_pkg;

  // Default number of AXI IDs in the pool.
  localparam int PRISM_AXI_NIDS = 8;

  // Retire FSM: wait for the head ID to complete, then offer it to the
  // allocator until it is accepted.
  typedef enum logic [0:0] {
    RT_IDLE  = 1'b0,
    RT_OFFER = 1'b1
  } rt_state_t;

endpackage : prism_axi_id_pkg
`default_nettype wire

// File: rtl/prism_axi_id_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prism_axi_id_order_fifo
//  Description : Circular FIFO recording AXI IDs in issue order. Pointers
//                carry an extra wrap bit so full and empty are distinguished
//                by pointer difference. Full, empty and count are registered.
//                DEPTH must be a power of two.
//  Ports       : clock, reset      - clock, synchronous active-high reset
//                i_push, i_push_id - write an ID (caller keeps off when full)
//                i_pop             - drop the head (caller keeps off when empty)
//                o_head_id         - oldest ID still in the FIFO
//                o_empty, o_full   - registered occupancy flags
//                o_full_next       - full flag as it will be after this edge
//                o_count           - number of stored IDs
//  Revision    : 1.0 - initial release
// ============================================================================
module prism_axi_id_order_fifo #(
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_push,
  input  logic [ID_WIDTH-1:0] i_push_id,
  input  logic                i_pop,
  output logic [ID_WIDTH-1:0] o_head_id,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_full_next,
  output logic [ID_WIDTH:0]   o_count
);

  localparam int PTR_W = ID_WIDTH + 1;
  localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [PTR_W-1:0]    count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic [ID_WIDTH-1:0] mem_q [DEPTH];
  logic [ID_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (i_push) begin
      mem_d[wptr_q[ID_WIDTH-1:0]] = i_push_id;
      wptr_d = wptr_q + C_ONE;
    end
    if (i_pop) begin
      rptr_d = rptr_q + C_ONE;
    end
    // Wrap bit makes the plain difference the occupancy, 0..DEPTH.
    count_d = wptr_d - rptr_d;
    empty_d = (count_d == '0);
    full_d  = (count_d == C_DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign o_head_id   = mem_q[rptr_q[ID_WIDTH-1:0]];
  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_full_next = full_d;
  assign o_count     = count_q;

endmodule : prism_axi_id_order_fifo
`default_nettype wire

// File: rtl/prism_axi_id_retirer.sv
`default_nettype none
// ============================================================================
//  Module      : prism_axi_id_retirer
//  Description : Releasing end of the AXI ID pool. Records issue order of
//                AR/AW IDs, snoops R/B for final beats and hands IDs back to
//                the allocator strictly in issue order once complete.
//  Ports       : clock, reset              - clock, sync active-high reset
//                issue_valid/ready/id      - accepted address beat tracking
//                resp_valid/ready/id/last  - R/B snoop (last tied high for B)
//                dealloc_valid/ready/id    - release to the allocator
//                outstanding               - issued, not yet released IDs
//                error                     - sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module prism_axi_id_retirer
  import prism_axi_id_pkg::*;
#(
  parameter int NIDS     = PRISM_AXI_NIDS,
  parameter int ID_WIDTH = $clog2(NIDS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ID_WIDTH-1:0] issue_id,
  input  logic                resp_valid,
  output logic                resp_ready,
  input  logic [ID_WIDTH-1:0] resp_id,
  input  logic                resp_last,
  output logic                dealloc_valid,
  input  logic                dealloc_ready,
  output logic [ID_WIDTH-1:0] dealloc_id,
  output logic [ID_WIDTH:0]   outstanding,
  output logic                error
);

  rt_state_t           state_q, state_d;
  logic [NIDS-1:0]     pending_q, pending_d;
  logic [NIDS-1:0]     done_q, done_d;
  logic                issue_ready_q, issue_ready_d;
  logic                resp_ready_q;
  logic                dealloc_valid_q, dealloc_valid_d;
  logic [ID_WIDTH-1:0] dealloc_id_q, dealloc_id_d;
  logic                error_q, error_d;

  logic                w_issue_fire, w_issue_err, w_push;
  logic                w_resp_fire, w_resp_err, w_resp_ok;
  logic                w_pop;
  logic [ID_WIDTH-1:0] w_head_id;
  logic                w_fifo_empty, w_fifo_full, w_fifo_full_next;
  logic [ID_WIDTH:0]   w_count;

  prism_axi_id_order_fifo #(
    .DEPTH    (NIDS),
    .ID_WIDTH (ID_WIDTH)
  ) u_order_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_id   (issue_id),
    .i_pop       (w_pop),
    .o_head_id   (w_head_id),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_full_next (w_fifo_full_next),
    .o_count     (w_count)
  );

  always_comb begin
    // All checks use pre-edge pending/done, so an ID whose release completes
    // this cycle still counts as pending for a simultaneous re-issue.
    w_issue_fire = issue_valid & issue_ready_q & ~w_fifo_full;
    w_issue_err  = w_issue_fire & pending_q[issue_id];
    w_push       = w_issue_fire & ~pending_q[issue_id];

    w_resp_fire  = resp_valid & resp_ready_q & resp_last;
    w_resp_err   = w_resp_fire & (~pending_q[resp_id] | done_q[resp_id]);
    w_resp_ok    = w_resp_fire & ~w_resp_err;

    // While offering, dealloc_id_q equals the FIFO head.
    w_pop        = (state_q == RT_OFFER) & dealloc_ready;

    pending_d = pending_q;
    done_d    = done_q;
    if (w_push)    pending_d[issue_id] = 1'b1;
    if (w_resp_ok) done_d[resp_id]     = 1'b1;
    if (w_pop) begin
      pending_d[dealloc_id_q] = 1'b0;
      done_d[dealloc_id_q]    = 1'b0;
    end

    error_d       = error_q | w_issue_err | w_resp_err;
    issue_ready_d = ~w_fifo_full_next;

    state_d         = state_q;
    dealloc_valid_d = dealloc_valid_q;
    dealloc_id_d    = dealloc_id_q;
    case (state_q)
      RT_IDLE: begin
        if (!w_fifo_empty && done_q[w_head_id]) begin
          dealloc_id_d    = w_head_id;
          dealloc_valid_d = 1'b1;
          state_d         = RT_OFFER;
        end
      end
      RT_OFFER: begin
        if (dealloc_ready) begin
          dealloc_valid_d = 1'b0;
          state_d         = RT_IDLE;
        end
      end
      default: begin
        dealloc_valid_d = 1'b0;
        state_d         = RT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= RT_IDLE;
      pending_q       <= '0;
      done_q          <= '0;
      issue_ready_q   <= 1'b0;
      resp_ready_q    <= 1'b0;
      dealloc_valid_q <= 1'b0;
      dealloc_id_q    <= '0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      done_q          <= done_d;
      issue_ready_q   <= issue_ready_d;
      resp_ready_q    <= 1'b1;
      dealloc_valid_q <= dealloc_valid_d;
      dealloc_id_q    <= dealloc_id_d;
      error_q         <= error_d;
    end
  end

  assign issue_ready   = issue_ready_q;
  assign resp_ready    = resp_ready_q;
  assign dealloc_valid = dealloc_valid_q;
  assign dealloc_id    = dealloc_id_q;
  assign outstanding   = w_count;
  assign error         = error_q;

endmodule : prism_axi_id_retirer
`default_nettype wire
